// File: rtl/g2b_bram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : g2b_bram_writer
//  Description : Writes a 256-bit ready/valid beat stream (from the GDDR6-to-
//                BRAM data processor) into consecutive BRAM lines. A command
//                (base address, line count) starts a transfer. Completion is
//                reported by a one-cycle done pulse and a written-line count.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk, i_reset            clock, asynchronous active-high reset
//    i_start                   command strobe (honoured only when idle)
//    i_base_addr, i_num_lines  command parameters, latched on accepted start
//    i_abort                   synchronous abort, no done pulse
//    o_busy, o_done            transfer status / one-cycle completion pulse
//    o_lines_written           beats written in the current or last transfer
//    i_data, i_valid, o_ready  input stream
//    o_bram_wr_en/addr/data    registered BRAM write port
// ============================================================================
module g2b_bram_writer #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 11,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_num_lines,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [LEN_WIDTH-1:0]  o_lines_written,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_bram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_bram_wr_addr,
  output logic [DATA_WIDTH-1:0] o_bram_wr_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [LEN_WIDTH-1:0]  r_lines_written;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  w_accept;
  logic                  w_start_ok;

  assign w_accept   = (r_state == S_WRITE) && i_valid;
  assign w_start_ok = (r_state == S_IDLE) && i_start;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    w_state_next = r_state;
    o_ready      = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = (i_num_lines != '0) ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        // Abort outranks completion; a beat taken this cycle is still written.
        if (i_abort) begin
          w_state_next = S_IDLE;
        end else if (w_accept && (r_remaining == LEN_WIDTH'(1))) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_busy       = 1'b1;
        o_done       = !i_abort;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: address/count tracking and registered BRAM write port
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr          <= '0;
      r_remaining     <= '0;
      r_lines_written <= '0;
      r_wr_en         <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_start_ok) begin
        r_addr          <= i_base_addr;
        r_remaining     <= i_num_lines;
        r_lines_written <= '0;
      end
      if (w_accept) begin
        r_wr_addr       <= r_addr;
        r_wr_data       <= i_data;
        // Natural overflow gives the modulo-2^ADDR_WIDTH wrap.
        r_addr          <= r_addr + ADDR_WIDTH'(1);
        r_remaining     <= r_remaining - LEN_WIDTH'(1);
        r_lines_written <= r_lines_written + LEN_WIDTH'(1);
      end
    end
  end

  assign o_lines_written = r_lines_written;
  assign o_bram_wr_en    = r_wr_en;
  assign o_bram_wr_addr  = r_wr_addr;
  assign o_bram_wr_data  = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_g2b_bram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_g2b_bram_writer
//  Description : Self-checking bench for g2b_bram_writer. A transfer-level
//                reference model predicts every output each cycle; directed
//                scenarios add literal expectations; a random phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_g2b_bram_writer;

  localparam int DW = 256;
  localparam int AW = 11;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [LW-1:0] i_num_lines = '0;
  logic          i_abort = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_valid = 1'b0;
  logic          o_busy, o_done, o_ready, o_bram_wr_en;
  logic [LW-1:0] o_lines_written;
  logic [AW-1:0] o_bram_wr_addr;
  logic [DW-1:0] o_bram_wr_data;

  int checks = 0;
  int errors = 0;

  g2b_bram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_num_lines(i_num_lines), .i_abort(i_abort), .o_busy(o_busy),
    .o_done(o_done), .o_lines_written(o_lines_written), .i_data(i_data),
    .i_valid(i_valid), .o_ready(o_ready), .o_bram_wr_en(o_bram_wr_en),
    .o_bram_wr_addr(o_bram_wr_addr), .o_bram_wr_data(o_bram_wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- Transfer-level reference model ----------------
  // A transfer is described by its base, length and how many beats have been
  // taken; the write address of beat k is (base + k) mod 2^AW.
  bit            m_active   = 1'b0;   // beats still being collected
  bit            m_done_due = 1'b0;   // completion cycle pending
  int            m_base     = 0;
  int            m_len      = 0;
  int            m_taken    = 0;
  bit            e_wr_en    = 1'b0;
  logic [AW-1:0] e_wr_addr  = '0;
  logic [DW-1:0] e_wr_data  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 0; m_done_due <= 0; m_base <= 0; m_len <= 0; m_taken <= 0;
      e_wr_en <= 0; e_wr_addr <= '0; e_wr_data <= '0;
    end else begin
      e_wr_en <= 0;
      if (!m_active && !m_done_due) begin
        if (i_start) begin
          m_base  <= int'(i_base_addr);
          m_len   <= int'(i_num_lines);
          m_taken <= 0;
          if (i_num_lines == 0) m_done_due <= 1;
          else                  m_active   <= 1;
        end
      end else if (m_active) begin
        if (i_valid) begin
          e_wr_en   <= 1;
          e_wr_addr <= AW'((m_base + m_taken) % (1 << AW));
          e_wr_data <= i_data;
          m_taken   <= m_taken + 1;
        end
        if (i_abort) m_active <= 0;
        else if (i_valid && (m_taken + 1 == m_len)) begin
          m_active   <= 0;
          m_done_due <= 1;
        end
      end else begin
        m_done_due <= 0;
      end
    end
  end

  // ---------------- Per-cycle compare + observation log ----------------
  logic [AW-1:0] obs_addr[$];
  int            n_done = 0;
  int            n_ready = 0;
  bit            done_with_wr = 0;
  logic [AW-1:0] done_addr = '0;

  always @(negedge clk) begin
    chk("busy",      DW'(o_busy),          DW'(m_active || m_done_due));
    chk("ready",     DW'(o_ready),         DW'(m_active));
    chk("done",      DW'(o_done),          DW'(m_done_due && !i_abort));
    chk("wr_en",     DW'(o_bram_wr_en),    DW'(e_wr_en));
    chk("wr_addr",   DW'(o_bram_wr_addr),  DW'(e_wr_addr));
    chk("wr_data",   o_bram_wr_data,       e_wr_data);
    chk("lines",     DW'(o_lines_written), DW'(m_taken));
    if (o_bram_wr_en) obs_addr.push_back(o_bram_wr_addr);
    if (o_ready) n_ready++;
    if (o_done) begin
      n_done++;
      done_with_wr = o_bram_wr_en;
      done_addr    = o_bram_wr_addr;
    end
  end

  // ---------------- Stimulus helpers (called #1 after a posedge) ----------------
  task automatic clear_log();
    obs_addr.delete();
    n_done = 0; n_ready = 0; done_with_wr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int base, input int len);
    i_start = 1; i_base_addr = AW'(base); i_num_lines = LW'(len);
    step();
    i_start = 0;
  endtask

  task automatic feed(input logic [31:0] pat, input int plen, input int maxcyc);
    int k = 0;
    while ((m_active || m_done_due) && k < maxcyc) begin
      i_valid = pat[k % plen];
      i_data  = rand256();
      step();
      k++;
    end
    i_valid = 0;
    checks++;
    if (m_active || m_done_due) begin
      errors++;
      $display("FAIL feed_timeout: transfer still busy after %0d cycles, required idle", k);
    end
  endtask

  task automatic chk_addrs(input string name, input int base, input int n);
    chk({name, "_count"}, DW'(obs_addr.size()), DW'(n));
    for (int i = 0; i < n && i < obs_addr.size(); i++)
      chk(name, DW'(obs_addr[i]), DW'((base + i) % 2048));
  endtask

  initial begin
    #12;
    // Reset state (rst has been high across the first edge)
    chk("rst_busy", DW'(o_busy), 0);
    chk("rst_wr_en", DW'(o_bram_wr_en), 0);
    chk("rst_lines", DW'(o_lines_written), 0);
    rst = 0;
    step();

    // Basic transfer
    clear_log();
    do_start('h010, 4);
    feed(32'h1, 1, 50);
    chk_addrs("basic_addr", 'h010, 4);
    chk("basic_ndone", DW'(n_done), 1);
    chk("basic_done_with_wr", DW'(done_with_wr), 1);
    chk("basic_done_addr", DW'(done_addr), DW'('h013));
    chk("basic_lines", DW'(o_lines_written), 4);
    chk("basic_busy_after", DW'(o_busy), 0);

    // Backpressure gaps: valid pattern 1,0,0,1,0,1
    clear_log();
    do_start('h200, 3);
    feed(32'b101001, 6, 50);
    chk_addrs("gap_addr", 'h200, 3);
    chk("gap_ndone", DW'(n_done), 1);
    chk("gap_done_with_wr", DW'(done_with_wr), 1);
    chk("gap_lines", DW'(o_lines_written), 3);

    // Address wrap
    clear_log();
    do_start('h7FE, 4);
    feed(32'h1, 1, 50);
    chk("wrap_a0", DW'(obs_addr[0]), DW'('h7FE));
    chk("wrap_a1", DW'(obs_addr[1]), DW'('h7FF));
    chk("wrap_a2", DW'(obs_addr[2]), DW'('h000));
    chk("wrap_a3", DW'(obs_addr[3]), DW'('h001));

    // Zero length
    clear_log();
    i_valid = 1;
    do_start('h055, 0);
    chk("zero_done", DW'(o_done), 1);
    step();
    i_valid = 0;
    chk("zero_done_after", DW'(o_done), 0);
    chk("zero_busy_after", DW'(o_busy), 0);
    chk("zero_lines", DW'(o_lines_written), 0);
    chk("zero_nready", DW'(n_ready), 0);
    chk("zero_nwr", DW'(obs_addr.size()), 0);

    // Abort after third acceptance
    clear_log();
    do_start('h040, 8);
    i_valid = 1;
    repeat (3) begin i_data = rand256(); step(); end
    i_valid = 0; i_abort = 1;
    step();
    i_abort = 0;
    step();
    chk_addrs("abort_addr", 'h040, 3);
    chk("abort_ndone", DW'(n_done), 0);
    chk("abort_lines", DW'(o_lines_written), 3);
    chk("abort_busy", DW'(o_busy), 0);

    // Start pulsed mid-transfer is ignored
    clear_log();
    do_start('h100, 5);
    for (int k = 0; k < 40 && (m_active || m_done_due); k++) begin
      i_valid = 1; i_data = rand256();
      i_start = (k == 2); i_base_addr = AW'('h200); i_num_lines = LW'(9);
      step();
    end
    i_start = 0; i_valid = 0;
    chk_addrs("ign_addr", 'h100, 5);
    chk("ign_lines", DW'(o_lines_written), 5);
    chk("ign_ndone", DW'(n_done), 1);

    // Asynchronous reset mid-transfer
    clear_log();
    do_start('h020, 10);
    i_valid = 1;
    repeat (3) begin i_data = rand256(); step(); end
    #2;
    rst = 1;
    #1;
    chk("arst_busy", DW'(o_busy), 0);
    chk("arst_ready", DW'(o_ready), 0);
    chk("arst_done", DW'(o_done), 0);
    chk("arst_wr_en", DW'(o_bram_wr_en), 0);
    chk("arst_wr_addr", DW'(o_bram_wr_addr), 0);
    chk("arst_wr_data", o_bram_wr_data, 0);
    chk("arst_lines", DW'(o_lines_written), 0);
    i_valid = 0;
    @(posedge clk); #3;
    rst = 0;
    step();
    chk("arst_ndone", DW'(n_done), 0);
    clear_log();
    do_start('h030, 2);
    feed(32'h1, 1, 50);
    chk_addrs("arst_new_addr", 'h030, 2);
    chk("arst_new_lines", DW'(o_lines_written), 2);
    chk("arst_new_ndone", DW'(n_done), 1);

    // Randomised transfers with bubbles, aborts and ignored starts
    for (int t = 0; t < 40; t++) begin
      int k;
      do_start($urandom_range(0, 2047), $urandom_range(0, 14));
      k = 0;
      while ((m_active || m_done_due) && k < 300) begin
        i_valid     = ($urandom_range(0, 3) != 0);
        i_data      = rand256();
        i_abort     = ($urandom_range(0, 29) == 0);
        i_start     = ($urandom_range(0, 9) == 0);
        i_base_addr = AW'($urandom_range(0, 2047));
        i_num_lines = LW'($urandom_range(0, 14));
        step();
        k++;
      end
      i_valid = 0; i_abort = 0; i_start = 0;
      checks++;
      if (m_active || m_done_due) begin
        errors++;
        $display("FAIL rand_timeout: transfer %0d still busy, required idle", t);
      end
      if ($urandom_range(0, 1) != 0) step();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
